nonrestoring_divider: RTL



---
 rtl/div_pkg.sv | 20 ++
 rtl/nonrestoring_divider_if.sv | 28 ++
 rtl/div_substep.sv | 24 ++
 rtl/nonrestoring_divider.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the non-restoring divider
// FSM state encoding, default width and counter width helper.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 8;
  localparam int DIV_CNT_W_DEFAULT = $clog2(DIV_WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Iteration counter width for a given operand width; never narrower than 1.
  function automatic int div_cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/nonrestoring_divider_if.sv
// rtl/nonrestoring_divider_if.sv - start/busy/done handshake bundle for the divider
// The master drives the request and operands; the slave returns status and results.
interface nonrestoring_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_substep.sv
// rtl/div_substep.sv - one combinational non-restoring division iteration
// Shifts the next dividend bit into the partial remainder, adds or subtracts |divisor|.
module div_substep
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH+1:0] prem,
  input  logic [WIDTH-1:0] qreg,
  input  logic [WIDTH:0]   dmag,
  output logic [WIDTH+1:0] prem_nx,
  output logic [WIDTH-1:0] qreg_nx
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] dext;

  // |prem| < |divisor| <= 2^(WIDTH-1), so dropping the top bit before the shift is lossless.
  assign shifted = {prem[WIDTH:0], qreg[WIDTH-1]};
  assign dext    = {1'b0, dmag};
  assign prem_nx = prem[WIDTH+1] ? (shifted + dext) : (shifted - dext);
  assign qreg_nx = {qreg[WIDTH-2:0], ~prem_nx[WIDTH+1]};

endmodule

// File: rtl/nonrestoring_divider.sv
// rtl/nonrestoring_divider.sv - sequential signed divider, one quotient bit per clock
// Optional DIV_OVERFLOW_SAT_EN saturates the -2^(WIDTH-1) / -1 quotient to the max positive value.
module nonrestoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nonrestoring_divider_if.slave bus
);

  localparam int             CW   = div_cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  div_state_e       state;
  logic [CW-1:0]    cnt;
  logic             neg_dvd;
  logic             neg_dvs;
  logic             dz;
  logic [WIDTH:0]   dvs_mag;
  logic [WIDTH+1:0] prem;
  logic [WIDTH-1:0] qreg;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;
  logic             dz_r;

  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH+1:0] prem_nx;
  logic [WIDTH-1:0] qreg_nx;
  logic [WIDTH-1:0] rmag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

`ifdef DIV_OVERFLOW_SAT_EN
  logic             ovf;
`endif

  // Unsigned WIDTH-bit magnitudes: -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits.
  assign dvd_abs = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
  assign dvs_abs = bus.divisor[WIDTH-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;

  div_substep #(.WIDTH(WIDTH)) u_step (
    .prem    (prem),
    .qreg    (qreg),
    .dmag    (dvs_mag),
    .prem_nx (prem_nx),
    .qreg_nx (qreg_nx)
  );

  // Final remainder magnitude is below |divisor|, so the restore only needs the low WIDTH bits.
  always_comb begin
    rmag  = prem[WIDTH+1] ? (prem[WIDTH-1:0] + dvs_mag[WIDTH-1:0]) : prem[WIDTH-1:0];
    q_fix = (neg_dvd ^ neg_dvs) ? (~qreg + 1'b1) : qreg;
    r_fix = neg_dvd ? (~rmag + 1'b1) : rmag;
    if (dz) begin
      q_fix = '1;
      r_fix = neg_dvd ? (~qreg + 1'b1) : qreg;
    end
`ifdef DIV_OVERFLOW_SAT_EN
    if (ovf) begin
      q_fix = {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      neg_dvd <= 1'b0;
      neg_dvs <= 1'b0;
      dz      <= 1'b0;
      dvs_mag <= '0;
      prem    <= '0;
      qreg    <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      quot_r  <= '0;
      rem_r   <= '0;
      dz_r    <= 1'b0;
`ifdef DIV_OVERFLOW_SAT_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg_dvd <= bus.dividend[WIDTH-1];
            neg_dvs <= bus.divisor[WIDTH-1];
            dvs_mag <= {1'b0, dvs_abs};
            qreg    <= dvd_abs;
            prem    <= '0;
            cnt     <= '0;
            dz      <= (bus.divisor == '0);
            dz_r    <= 1'b0;
            busy_r  <= 1'b1;
`ifdef DIV_OVERFLOW_SAT_EN
            ovf     <= (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.divisor == '1);
`endif
            state   <= (bus.divisor == '0) ? FIX : RUN;
          end
        end
        RUN: begin
          prem <= prem_nx;
          qreg <= qreg_nx;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          quot_r <= q_fix;
          rem_r  <= r_fix;
          dz_r   <= dz;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dz_r;

endmodule
